lfsr_seq_checker: RTL

Downstream monitor for the 8-bit one-to-many LFSR (x^8+x^4+x^3+x^2+1, seed 8'hBD). It samples the generator output each valid cycle and locks onto the sequence. Once locked, it flywheels a predicted next value, counts mismatches and measures the sequence period. It sits between the LFSR and the lab status/LED logic as a self-check for the generator.

---
 rtl/lfsr_pkg.sv | 17 +
 rtl/lfsr_period_meter.sv | 44 ++++
 rtl/lfsr_seq_checker.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the 8-bit LFSR (x^8+x^4+x^3+x^2+1) and its checker.
package lfsr_pkg;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    SYNC   = 2'd1,
    LOCKED = 2'd2
  } lfsr_state_e;

  localparam logic [7:0] LFSR_SEED = 8'hBD;

  // One generator advance; step(8'hBD) == 8'h67.
  function automatic logic [7:0] step(input logic [7:0] c);
    return {c[6], c[5], c[4], c[3] ^ c[7], c[2] ^ c[7], c[1] ^ c[7], c[0], c[7]};
  endfunction

endpackage

// File: rtl/lfsr_period_meter.sv
// Measures SEED-to-SEED sample distance while the checker is locked.
module lfsr_period_meter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample,
  input  logic       is_seed,
  input  logic       enable,
  input  logic       clr,
  output logic [8:0] period,
  output logic       period_valid
);

  logic       armed;
  logic [8:0] cnt;

  // Arm on the first seed, count samples, publish the count at the next seed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed        <= 1'b0;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (sample) begin
        if (!enable) begin
          armed <= 1'b0;
          cnt   <= '0;
        end else if (is_seed) begin
          armed <= 1'b1;
          cnt   <= 9'd1;
          if (armed) begin
            period       <= cnt;
            period_valid <= 1'b1;
          end
        end else if (armed && (cnt != '1)) begin
          cnt <= cnt + 9'd1;
        end
      end
      if (clr) period <= '0;
    end
  end

endmodule

// File: rtl/lfsr_seq_checker.sv
// Locks onto the LFSR stream, flywheels a prediction, counts mispredictions
// and reports the sequence period.
module lfsr_seq_checker
  import lfsr_pkg::*;
#(
  parameter int unsigned LOCK_N = 4,
  parameter int unsigned LOSS_N = 3,
  parameter int unsigned CNT_W  = 16,
  parameter logic [7:0]  SEED   = LFSR_SEED
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  input  logic             clr,
  output logic             locked,
  output logic             err_pulse,
  output logic [CNT_W-1:0] err_cnt,
  output logic [8:0]       period,
  output logic             period_valid,
  output logic             zero_seen
);

  localparam int unsigned MW = $clog2(LOCK_N + 1);
  localparam int unsigned SW = $clog2(LOSS_N + 1);
  localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_N);
  localparam logic [SW-1:0] LOSS_MAX = SW'(LOSS_N);

  lfsr_state_e      state, state_nxt;
  logic [7:0]       prev, prev_nxt, pred;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic [SW-1:0]    miss_cnt, miss_nxt;
  logic [CNT_W-1:0] err_cnt_nxt;
  logic             err_hit, zero_nxt;

  // State and counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= HUNT;
      prev      <= '0;
      match_cnt <= '0;
      miss_cnt  <= '0;
      err_cnt   <= '0;
      err_pulse <= 1'b0;
      zero_seen <= 1'b0;
    end else begin
      state     <= state_nxt;
      prev      <= prev_nxt;
      match_cnt <= match_nxt;
      miss_cnt  <= miss_nxt;
      err_cnt   <= err_cnt_nxt;
      err_pulse <= err_hit;
      zero_seen <= zero_nxt;
    end
  end

  // Next-state, prediction and error bookkeeping.
  always_comb begin
    state_nxt   = state;
    prev_nxt    = prev;
    match_nxt   = match_cnt;
    miss_nxt    = miss_cnt;
    err_hit     = 1'b0;
    pred        = step(prev);
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (in_data != '0) begin
            prev_nxt  = in_data;
            match_nxt = '0;
            state_nxt = SYNC;
          end
        end
        SYNC: begin
          prev_nxt = in_data;
          if (in_data == pred) begin
            match_nxt = match_cnt + 1'b1;
            if (match_nxt == LOCK_MAX) begin
              state_nxt = LOCKED;
              miss_nxt  = '0;
            end
          end else begin
            match_nxt = '0;
            if (in_data == '0) state_nxt = HUNT;
          end
        end
        LOCKED: begin
          // Flywheel: the prediction advances even over a corrupted sample.
          prev_nxt = pred;
          if (in_data == pred) begin
            miss_nxt = '0;
          end else begin
            err_hit  = 1'b1;
            miss_nxt = miss_cnt + 1'b1;
            if (miss_nxt == LOSS_MAX) begin
              state_nxt = SYNC;
              prev_nxt  = in_data;
              match_nxt = '0;
              miss_nxt  = '0;
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end

    err_cnt_nxt = err_cnt;
    if (clr) err_cnt_nxt = '0;
    else if (err_hit && (err_cnt != '1)) err_cnt_nxt = err_cnt + 1'b1;

    zero_nxt = zero_seen;
    if (clr) zero_nxt = 1'b0;
    else if (in_valid && (in_data == '0)) zero_nxt = 1'b1;
  end

  assign locked = (state == LOCKED);

  lfsr_period_meter u_meter (
    .clk          (clk),
    .rst_n        (rst_n),
    .sample       (in_valid),
    .is_seed      (in_data == SEED),
    .enable       (state == LOCKED),
    .clr          (clr),
    .period       (period),
    .period_valid (period_valid)
  );

endmodule
